// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, late results
// queue in a small FIFO with bounded starvation and WAW squashing of stale entries.
module wb_port_arbiter #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p_valid,
  input  logic [4:0]                 p_rd,
  input  logic [N-1:0]               p_data,
  output logic                       p_stall,
  input  logic                       s_valid,
  input  logic [4:0]                 s_rd,
  input  logic [N-1:0]               s_data,
  output logic                       s_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd,
  output logic [N-1:0]               rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  logic [4:0]       rd_q   [DEPTH];
  logic [N-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] sq_q;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [SW-1:0]    starve_cnt;

  logic empty, head_sq, push, pop, p_grant, h_grant;

  // Handshakes: a push happens when s_valid & s_ready at the edge; p_stall high
  // means the primary write was not taken this cycle and must be held.
  assign empty   = (fifo_count == '0);
  assign head_sq = sq_q[rd_ptr];
  assign s_ready = (fifo_count != CW'(DEPTH));
  assign push    = s_valid & s_ready;
  assign p_stall = p_valid & ~p_grant;

  always_comb begin
    p_grant = 1'b0;
    h_grant = 1'b0;
    pop     = 1'b0;
    if (empty) begin
      p_grant = p_valid;
    end else if (head_sq) begin
      // Stale head drains silently and never costs the primary a cycle.
      pop     = 1'b1;
      p_grant = p_valid;
    end else if (!p_valid || starve_cnt == SW'(STARVE_MAX)) begin
      h_grant = 1'b1;
      pop     = 1'b1;
    end else begin
      p_grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (p_grant) begin
      rf_we    <= (p_rd != 5'd0);
      rf_rd    <= p_rd;
      rf_wdata <= p_data;
    end else if (h_grant) begin
      rf_we    <= (rd_q[rd_ptr] != 5'd0);
      rf_rd    <= rd_q[rd_ptr];
      rf_wdata <= data_q[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      sq_q       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // Queued results are older than the primary write granted now.
      for (int i = 0; i < DEPTH; i++) begin
        if (p_grant && p_rd != 5'd0 && vld_q[i] && rd_q[i] == p_rd)
          sq_q[i] <= 1'b1;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        sq_q[rd_ptr]  <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      if (push) begin
        rd_q[wr_ptr]   <= s_rd;
        data_q[wr_ptr] <= s_data;
        vld_q[wr_ptr]  <= 1'b1;
        sq_q[wr_ptr]   <= 1'b0;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected regfile writes are queued by the
// stimulus and retired by an independent monitor watching rf_we.
module tb_wb_port_arbiter;

  localparam int N = 32;
  localparam int W = 5 + N;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_valid;
  logic [4:0]    p_rd;
  logic [N-1:0]  p_data;
  logic          p_stall;
  logic          s_valid;
  logic [4:0]    s_rd;
  logic [N-1:0]  s_data;
  logic          s_ready;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [N-1:0]  rf_wdata;
  logic [2:0]    fifo_count;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.N(N), .DEPTH(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
    .s_valid(s_valid), .s_rd(s_rd), .s_data(s_data), .s_ready(s_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic pv, input logic [4:0] prd, input logic [N-1:0] pd,
                       input logic sv, input logic [4:0] srd, input logic [N-1:0] sd);
    p_valid = pv; p_rd = prd; p_data = pd;
    s_valid = sv; s_rd = srd; s_data = sd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [N-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_rd, rf_wdata}, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_rd, rf_wdata}, {27'd0, e});
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("reset_count", 64'(fifo_count), 64'd0);
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd1);

    // primary only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("prim_stall", 64'(p_stall), 64'd0);
    expect_wr(5, 32'hDEADBEEF);
    tick();
    chk("prim_we", 64'(rf_we), 64'd1);

    // starvation: four lost cycles, then the head is forced
    drive(0, 0, 0, 1, 7, 32'h11);
    tick();
    chk("starve_count", 64'(fifo_count), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 32'h100 + i, 0, 0, 0);
      chk("starve_lose_stall", 64'(p_stall), 64'd0);
      expect_wr(3, 32'h100 + i);
      tick();
    end
    drive(1, 3, 32'h200, 0, 0, 0);
    chk("starve_forced_stall", 64'(p_stall), 64'd1);
    expect_wr(7, 32'h11);
    tick();
    chk("starve_pop_count", 64'(fifo_count), 64'd0);
    drive(1, 3, 32'h201, 0, 0, 0);
    chk("starve_resume_stall", 64'(p_stall), 64'd0);
    expect_wr(3, 32'h201);
    tick();

    // WAW squash
    drive(0, 0, 0, 1, 9, 32'h99);
    tick();
    drive(1, 9, 32'h22, 0, 0, 0);
    chk("squash_prim_stall", 64'(p_stall), 64'd0);
    expect_wr(9, 32'h22);
    tick();
    drive(1, 4, 32'h33, 0, 0, 0);
    chk("squash_pop_stall", 64'(p_stall), 64'd0);
    expect_wr(4, 32'h33);
    tick();
    chk("squash_count", 64'(fifo_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // full FIFO
    for (int i = 0; i < 4; i++) begin
      drive(1, 6, 32'h600 + i, 1, 5'(10 + i), 32'hA0 + i);
      chk("full_fill_ready", 64'(s_ready), 64'd1);
      expect_wr(6, 32'h600 + i);
      tick();
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    drive(1, 6, 32'h604, 1, 14, 32'hEE);
    chk("full_ready_low", 64'(s_ready), 64'd0);
    chk("full_p_stall", 64'(p_stall), 64'd0);
    expect_wr(6, 32'h604);
    tick();
    chk("full_hold_count", 64'(fifo_count), 64'd4);
    drive(1, 6, 32'h605, 1, 14, 32'hEE);
    chk("full_forced_stall", 64'(p_stall), 64'd1);
    chk("full_ready_during_pop", 64'(s_ready), 64'd0);
    expect_wr(10, 32'hA0);
    tick();
    chk("full_after_pop_count", 64'(fifo_count), 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    chk("full_ready_rises", 64'(s_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      expect_wr(5'(10 + i), 32'hA0 + i);
      tick();
    end
    chk("full_drained", 64'(fifo_count), 64'd0);

    // rd = 0 secondary
    drive(0, 0, 0, 1, 0, 32'h55);
    tick();
    chk("rd0_count_push", 64'(fifo_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("rd0_count_pop", 64'(fifo_count), 64'd0);
    chk("rd0_we", 64'(rf_we), 64'd0);

    // reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 1, 5'(20 + i), 32'hB0 + i);
      tick();
    end
    chk("rst_pre_count", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    drive(0, 0, 0, 1, 25, 32'hCC);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    tick(); tick(); tick();
    chk("rst_count_stays", 64'(fifo_count), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
